// File: rtl/pcm_frame_packer_if.sv
// PCM frame handshake and TX byte-FIFO write port of pcm_frame_packer.
// The packer uses the slave modport; the frame producer / FIFO side uses master.
interface pcm_frame_packer_if #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int CHANNELS     = 2,
  parameter int SPACE_WIDTH  = 18
);
  logic                             pcm_valid;
  logic [CHANNELS*SAMPLE_WIDTH-1:0] pcm_data;
  logic                             pcm_ready;
  logic [SPACE_WIDTH-1:0]           fifo_space;
  logic                             fifo_wr_en;
  logic [7:0]                       fifo_wr_data;

  modport master (
    output pcm_valid, pcm_data, fifo_space,
    input  pcm_ready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  pcm_valid, pcm_data, fifo_space,
    output pcm_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/pcm_frame_packer.sv
// Packs one multi-channel PCM frame per handshake into the SPI TX byte FIFO,
// optionally prefixed by a sync byte and sequence byte; frames that do not fit are dropped whole.
module pcm_frame_packer #(
  parameter int         SAMPLE_WIDTH     = 24,
  parameter int         CHANNELS         = 2,
  parameter int         BYTES_PER_SAMPLE = 2,
  parameter int         HEADER_EN        = 1,
  parameter logic [7:0] HEADER_BYTE      = 8'hA5,
  parameter int         SPACE_WIDTH      = 18,
  parameter int         DROP_CNT_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pcm_frame_packer_if.slave         bus,
  input  logic                      capture_en_i,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      drop_pulse_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_count_o,
  output logic [7:0]                seq_num_o
);

  localparam int HDR_BYTES = (HEADER_EN != 0) ? 2 : 0;
  localparam int FB        = HDR_BYTES + CHANNELS * BYTES_PER_SAMPLE;
  localparam int KEEP_W    = 8 * BYTES_PER_SAMPLE;
  localparam int CNT_W     = $clog2(FB + 1);

  localparam logic [SPACE_WIDTH-1:0] FB_SPACE = SPACE_WIDTH'(FB);
  localparam logic [CNT_W-1:0]       LAST_IDX = CNT_W'(FB - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                    state_q;
  logic [FB*8-1:0]           shift_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      pcm_ready_q;
  logic                      wr_en_q;
  logic [7:0]                wr_data_q;
  logic                      busy_q;
  logic                      frame_done_q;
  logic                      drop_pulse_q;
  logic [DROP_CNT_WIDTH-1:0] drop_count_q;
  logic [7:0]                seq_num_q;

  // Whole frame laid out in emission order, byte 0 in the LSBs.
  logic [FB*8-1:0] frame_bytes;

  if (HEADER_EN != 0) begin : g_hdr
    assign frame_bytes[15:0] = {seq_num_q, HEADER_BYTE};
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign frame_bytes[(HDR_BYTES + c*BYTES_PER_SAMPLE)*8 +: KEEP_W] =
      bus.pcm_data[c*SAMPLE_WIDTH + SAMPLE_WIDTH - 1 -: KEEP_W];
  end

  // Sample LSBs below the kept bytes are truncated on purpose.
  logic unused_lsbs;
  assign unused_lsbs = ^bus.pcm_data;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and simulation matches the netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      // NOTE: the byte shift register is reset along with the control state,
      // so an abandoned frame can never leak residual bytes later.
      shift_q      <= '0;
      cnt_q        <= '0;
      pcm_ready_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
      seq_num_q    <= '0;
    end else begin
      drop_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          pcm_ready_q <= 1'b1;
          if (bus.pcm_valid && pcm_ready_q && capture_en_i) begin
            if (bus.fifo_space >= FB_SPACE) begin
              state_q      <= EMIT;
              pcm_ready_q  <= 1'b0;
              busy_q       <= 1'b1;
              wr_en_q      <= 1'b1;
              wr_data_q    <= frame_bytes[7:0];
              shift_q      <= frame_bytes >> 8;
              cnt_q        <= LAST_IDX;
              frame_done_q <= (LAST_IDX == '0);
            end else begin
              drop_pulse_q <= 1'b1;
              seq_num_q    <= seq_num_q + 8'd1;
              if (drop_count_q != '1) begin
                drop_count_q <= drop_count_q + 1'b1;
              end
            end
          end
        end

        EMIT: begin
          if (cnt_q == '0) begin
            // Last byte has just been presented: close the frame.
            state_q      <= IDLE;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            pcm_ready_q  <= 1'b1;
            seq_num_q    <= seq_num_q + 8'd1;
          end else begin
            wr_data_q    <= shift_q[7:0];
            shift_q      <= shift_q >> 8;
            cnt_q        <= cnt_q - 1'b1;
            frame_done_q <= (cnt_q == CNT_W'(1));
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pcm_ready    = pcm_ready_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign busy_o           = busy_q;
  assign frame_done_o     = frame_done_q;
  assign drop_pulse_o     = drop_pulse_q;
  assign drop_count_o     = drop_count_q;
  assign seq_num_o        = seq_num_q;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Self-checking bench for pcm_frame_packer: default build plus a headerless
// single-channel 3-byte build, checked against a byte-queue reference model.
module tb_pcm_frame_packer;

  localparam int SW  = 24;
  localparam int CH  = 2;
  localparam int BPS = 2;
  localparam int FB  = 2 + CH * BPS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cap_a, cap_b;
  logic       busy_a, done_a, dpulse_a;
  logic [7:0] dcnt_a, seq_a;
  logic       busy_b, done_b, dpulse_b;
  logic [7:0] dcnt_b, seq_b;

  pcm_frame_packer_if #(.SAMPLE_WIDTH(24), .CHANNELS(2), .SPACE_WIDTH(18)) bus_a ();
  pcm_frame_packer_if #(.SAMPLE_WIDTH(24), .CHANNELS(1), .SPACE_WIDTH(18)) bus_b ();

  pcm_frame_packer dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .capture_en_i(cap_a),
    .busy_o(busy_a), .frame_done_o(done_a), .drop_pulse_o(dpulse_a),
    .drop_count_o(dcnt_a), .seq_num_o(seq_a)
  );

  pcm_frame_packer #(.CHANNELS(1), .BYTES_PER_SAMPLE(3), .HEADER_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .capture_en_i(cap_b),
    .busy_o(busy_b), .frame_done_o(done_b), .drop_pulse_o(dpulse_b),
    .drop_count_o(dcnt_b), .seq_num_o(seq_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitors, sampled on the falling edge.
  logic [7:0] mon_a[$];
  logic [7:0] mon_b[$];
  int         wr_t_b[$];
  int         done_a_cnt = 0;
  int         drop_a_cnt = 0;
  int         cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus_a.fifo_wr_en) mon_a.push_back(bus_a.fifo_wr_data);
    if (done_a)           done_a_cnt++;
    if (dpulse_a)         drop_a_cnt++;
    if (bus_b.fifo_wr_en) begin
      mon_b.push_back(bus_b.fifo_wr_data);
      wr_t_b.push_back(cyc);
    end
  end

  // Reference model: frame = optional header + each channel's top bytes, LSB first.
  int         model_seq   = 0;
  int         model_drops = 0;
  logic [7:0] exp_q[$];

  task automatic model_frame(input logic [47:0] d, input logic [17:0] sp, input logic cap);
    logic [23:0] sample;
    logic [23:0] kept;
    exp_q = {};
    if (!cap) return;
    if (int'(sp) < FB) begin
      model_seq = (model_seq + 1) % 256;
      if (model_drops < 255) model_drops++;
      return;
    end
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(model_seq));
    for (int c = 0; c < CH; c++) begin
      sample = d[c*SW +: SW];
      kept   = sample >> (SW - 8*BPS);
      for (int b = 0; b < BPS; b++) exp_q.push_back(kept[8*b +: 8]);
    end
    model_seq = (model_seq + 1) % 256;
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [47:0] d, input logic [17:0] sp, input logic cap);
    int waited = 0;
    while (!bus_a.pcm_ready && waited < 50) begin
      step();
      waited++;
    end
    check("send_a_ready", 32'(bus_a.pcm_ready), 1);
    bus_a.pcm_valid  = 1'b1;
    bus_a.pcm_data   = d;
    bus_a.fifo_space = sp;
    cap_a            = cap;
    step();
    bus_a.pcm_valid  = 1'b0;
  endtask

  task automatic cmp_bytes(input string name);
    check({name, "_len"}, mon_a.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_a.size(); i++)
      check($sformatf("%s_b%0d", name, i), mon_a[i], exp_q[i]);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    model_seq   = 0;
    model_drops = 0;
    step();
  endtask

  typedef struct {
    logic [47:0] data;
    logic [17:0] space;
    logic        cap;
    bit          exp_written;
    bit          exp_drop;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] first_bytes[6];
  logic [7:0] b_bytes[3];

  initial begin
    int          drops0;
    int          limit;
    logic [47:0] rd;
    logic [17:0] rs;
    logic        rc;
    bit          rw, rdp;

    vecs[0] = '{{24'hFFFFFF, 24'h000000}, 18'd1000, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{{24'h13579B, 24'h2468AC}, 18'd6,    1'b1, 1'b1, 1'b0};
    vecs[2] = '{{24'h111111, 24'h222222}, 18'd5,    1'b1, 1'b0, 1'b1};
    vecs[3] = '{{24'h333333, 24'h444444}, 18'd0,    1'b1, 1'b0, 1'b1};
    vecs[4] = '{{24'h555555, 24'h666666}, 18'd1000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{{24'h777777, 24'h888888}, 18'd0,    1'b0, 1'b0, 1'b0};
    vecs[6] = '{{24'hFF0000, 24'h0000FF}, 18'd7,    1'b1, 1'b1, 1'b0};
    vecs[7] = '{{24'($urandom), 24'($urandom)}, 18'd1000, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{{24'($urandom), 24'($urandom)}, 18'd2,    1'b1, 1'b0, 1'b1};
    vecs[9] = '{{24'h800001, 24'h7FFFFF}, 18'd6,    1'b1, 1'b1, 1'b0};

    first_bytes = '{8'hA5, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
    b_bytes     = '{8'h01, 8'h00, 8'h80};

    rst_n = 1'b0;
    cap_a = 1'b1;
    cap_b = 1'b1;
    bus_a.pcm_valid = 1'b0; bus_a.pcm_data = '0; bus_a.fifo_space = '0;
    bus_b.pcm_valid = 1'b0; bus_b.pcm_data = '0; bus_b.fifo_space = 18'd1000;

    // Reset state
    step(2);
    check("rst_ready", 32'(bus_a.pcm_ready), 0);
    check("rst_wr_en", 32'(bus_a.fifo_wr_en), 0);
    check("rst_busy",  32'(busy_a), 0);
    check("rst_done",  32'(done_a), 0);
    check("rst_drop",  32'(dpulse_a), 0);
    check("rst_dcnt",  32'(dcnt_a), 0);
    check("rst_seq",   32'(seq_a), 0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", 32'(bus_a.pcm_ready), 1);

    // Cycle-exact first frame
    mon_a = {};
    model_frame({24'hABCDEF, 24'h123456}, 18'd1000, 1'b1);
    send_a({24'hABCDEF, 24'h123456}, 18'd1000, 1'b1);
    for (int k = 0; k < FB; k++) begin
      check($sformatf("f1_wr_en%0d", k), 32'(bus_a.fifo_wr_en), 1);
      check($sformatf("f1_data%0d", k),  32'(bus_a.fifo_wr_data), 32'(first_bytes[k]));
      check($sformatf("f1_done%0d", k),  32'(done_a), (k == FB-1) ? 1 : 0);
      check($sformatf("f1_busy%0d", k),  32'(busy_a), 1);
      check($sformatf("f1_ready%0d", k), 32'(bus_a.pcm_ready), 0);
      step();
    end
    check("f1_end_wr_en", 32'(bus_a.fifo_wr_en), 0);
    check("f1_end_busy",  32'(busy_a), 0);
    check("f1_end_ready", 32'(bus_a.pcm_ready), 1);
    check("f1_end_seq",   32'(seq_a), 1);

    // Drop on insufficient space, then exact-fit frame
    mon_a = {};
    model_frame({24'h0, 24'h0}, 18'd5, 1'b1);
    send_a({24'h0, 24'h0}, 18'd5, 1'b1);
    check("drop_pulse", 32'(dpulse_a), 1);
    check("drop_wr_en", 32'(bus_a.fifo_wr_en), 0);
    check("drop_ready", 32'(bus_a.pcm_ready), 1);
    check("drop_cnt",   32'(dcnt_a), 1);
    check("drop_seq",   32'(seq_a), 2);
    step();
    check("drop_pulse_once", 32'(dpulse_a), 0);
    check("drop_no_bytes", mon_a.size(), 0);

    mon_a = {};
    model_frame({24'hFEDCBA, 24'h654321}, 18'd6, 1'b1);
    send_a({24'hFEDCBA, 24'h654321}, 18'd6, 1'b1);
    step(FB + 1);
    cmp_bytes("fit6");
    if (mon_a.size() > 1) check("fit6_seqbyte", mon_a[1], 8'h02);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      mon_a  = {};
      drops0 = drop_a_cnt;
      model_frame(vecs[i].data, vecs[i].space, vecs[i].cap);
      send_a(vecs[i].data, vecs[i].space, vecs[i].cap);
      step(FB + 1);
      check($sformatf("vec%0d_written", i), 32'(mon_a.size() != 0), 32'(vecs[i].exp_written));
      check($sformatf("vec%0d_drop", i), drop_a_cnt - drops0, 32'(vecs[i].exp_drop));
      cmp_bytes($sformatf("vec%0d", i));
      check($sformatf("vec%0d_seq", i),  32'(seq_a), model_seq);
      check($sformatf("vec%0d_dcnt", i), 32'(dcnt_a), model_drops);
    end

    // Randomized frames against the model
    for (int i = 0; i < 40; i++) begin
      mon_a  = {};
      drops0 = drop_a_cnt;
      rd = {24'($urandom), 24'($urandom)};
      rs = 18'($urandom_range(0, 10));
      rc = ($urandom_range(0, 3) != 0);
      model_frame(rd, rs, rc);
      rdp = rc && (int'(rs) < FB);
      rw  = (exp_q.size() != 0);
      send_a(rd, rs, rc);
      step(FB + 1 + $urandom_range(0, 2));
      cmp_bytes($sformatf("rnd%0d", i));
      check($sformatf("rnd%0d_drop", i), drop_a_cnt - drops0, 32'(rdp));
      check($sformatf("rnd%0d_busy", i), 32'(busy_a), 0);
      check($sformatf("rnd%0d_seq", i),  32'(seq_a), model_seq);
      check($sformatf("rnd%0d_dcnt", i), 32'(dcnt_a), model_drops);
      if (!rw) check($sformatf("rnd%0d_nowr", i), mon_a.size(), 0);
    end

    // capture_en falls during the 3rd byte: frame still completes
    mon_a = {};
    model_frame({24'hCAFE12, 24'hBEEF34}, 18'd1000, 1'b1);
    send_a({24'hCAFE12, 24'hBEEF34}, 18'd1000, 1'b1);
    step(2);
    cap_a = 1'b0;
    step(FB);
    cmp_bytes("capoff_mid");

    // capture_en=0: accepted and discarded, nothing changes
    mon_a  = {};
    drops0 = drop_a_cnt;
    for (int i = 0; i < 3; i++) begin
      model_frame({24'h123123, 24'h456456}, 18'd1000, 1'b0);
      send_a({24'h123123, 24'h456456}, 18'd1000, 1'b0);
    end
    step(FB);
    check("capoff_nowr",  mon_a.size(), 0);
    check("capoff_nodrop", drop_a_cnt - drops0, 0);
    check("capoff_seq",   32'(seq_a), model_seq);

    // Headerless build: back-to-back frames with a one-cycle gap
    bus_b.pcm_data  = 24'h800001;
    bus_b.pcm_valid = 1'b1;
    limit = 0;
    while (mon_b.size() < 9 && limit < 60) begin
      step();
      limit++;
    end
    bus_b.pcm_valid = 1'b0;
    step(5);
    check("b_len", mon_b.size(), 9);
    for (int i = 0; i < 9 && i < mon_b.size(); i++) begin
      check($sformatf("b_byte%0d", i), mon_b[i], b_bytes[i % 3]);
      check($sformatf("b_time%0d", i), wr_t_b[i] - wr_t_b[0], (i / 3) * 4 + (i % 3));
    end

    // Asynchronous reset after the 2nd byte
    mon_a = {};
    cap_a = 1'b1;
    send_a({24'h111111, 24'h222222}, 18'd1000, 1'b1);
    step();
    #6 rst_n = 1'b0;
    #1;
    check("arst_wr_en", 32'(bus_a.fifo_wr_en), 0);
    check("arst_busy",  32'(busy_a), 0);
    check("arst_ready", 32'(bus_a.pcm_ready), 0);
    check("arst_bytes", mon_a.size(), 2);
    step(2);
    rst_n = 1'b1;
    model_seq   = 0;
    model_drops = 0;
    step();
    mon_a = {};
    model_frame({24'h99AA55, 24'h66BB44}, 18'd1000, 1'b1);
    send_a({24'h99AA55, 24'h66BB44}, 18'd1000, 1'b1);
    step(FB + 3);
    cmp_bytes("post_rst");

    // 256 written frames wrap seq_num
    do_reset();
    mon_a = {};
    done_a_cnt = 0;
    bus_a.pcm_data   = {24'($urandom), 24'($urandom)};
    bus_a.fifo_space = 18'd1000;
    bus_a.pcm_valid  = 1'b1;
    limit = 0;
    while (done_a_cnt < 256 && limit < 256 * (FB + 1) + 50) begin
      step();
      limit++;
    end
    bus_a.pcm_valid = 1'b0;
    step(FB + 2);
    check("wrap_frames", done_a_cnt, 256);
    check("wrap_bytes",  mon_a.size(), 256 * FB);
    check("wrap_seq",    32'(seq_a), 0);

    // 300 consecutive drops saturate the counter
    drops0 = drop_a_cnt;
    bus_a.fifo_space = 18'd0;
    bus_a.pcm_valid  = 1'b1;
    step(300);
    bus_a.pcm_valid  = 1'b0;
    step(2);
    check("sat_pulses", drop_a_cnt - drops0, 300);
    check("sat_dcnt",   32'(dcnt_a), 8'hFF);
    check("sat_seq",    32'(seq_a), 300 % 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
